// File: rtl/regbank_p8_pkg.sv
// Shared definitions for the 8-register bank and the blocks that drive its instruction port.
// Instruction layout: opcode in [11:8], immediate in [7:0].
package regbank_p8_pkg;

    localparam int INST_WIDTH   = 12;
    localparam int OPCODE_HI    = 11;
    localparam int OPCODE_LO    = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD0 = 4'd1,
        OP_LD1 = 4'd2,
        OP_LD2 = 4'd3,
        OP_LD3 = 4'd4,
        OP_LD4 = 4'd5,
        OP_LD5 = 4'd6,
        OP_LD6 = 4'd7,
        OP_LD7 = 4'd8
    } opcode_t;

    localparam logic [3:0] OPCODE_MAX = OP_LD7;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    function automatic logic [3:0] inst_opcode(input logic [INST_WIDTH-1:0] inst);
        return inst[OPCODE_HI:OPCODE_LO];
    endfunction

    function automatic logic [7:0] inst_imm(input logic [INST_WIDTH-1:0] inst);
        return inst[7:0];
    endfunction

    function automatic logic opcode_legal(input logic [3:0] opcode);
        return opcode <= OPCODE_MAX;
    endfunction

endpackage

// File: rtl/regbank_p8_arbiter_rr_arb2.sv
// Two-way round-robin pick with a lock override; purely combinational.
// The pointer and lock registers live in the parent.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    input  logic       lock_hold,
    input  logic       held_idx,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock_hold) begin
            // a held grant starves the other side even while the holder is idle
            grant[held_idx] = valid[held_idx];
        end else if (valid == 2'b11) begin
            grant[pointer] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/regbank_p8_arbiter.sv
// Shares the bank's single instruction port between two requesters, screening illegal
// opcodes so the bank never sees one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | first clock after reset release, no grants
// ST_READY | arbitrating every cycle, forwarding legal instructions
// ST_ERROR | illegal opcode seen; terminal until reset, nothing accepted
module regbank_p8_arbiter #(
    parameter int         INST_WIDTH  = regbank_p8_pkg::INST_WIDTH,
    parameter logic [3:0] OPCODE_MAX  = regbank_p8_pkg::OPCODE_MAX,
    parameter int         COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INST_WIDTH-1:0]  req0_inst,
    input  logic                   req0_valid,
    input  logic                   req0_lock,
    output logic                   req0_ready,
    input  logic [INST_WIDTH-1:0]  req1_inst,
    input  logic                   req1_valid,
    input  logic                   req1_lock,
    output logic                   req1_ready,
    output logic [INST_WIDTH-1:0]  bank_inst,
    output logic                   bank_inst_en,
    output logic                   last_grant,
    output logic [COUNT_WIDTH-1:0] issue_count,
    output logic                   error
);
    import regbank_p8_pkg::*;

    state_t                state;
    logic                  pointer;
    logic                  lock_hold;
    logic                  held_idx;
    logic [1:0]            grant;
    logic                  arb_open;
    logic                  sel_idx;
    logic                  sel_lock;
    logic                  sel_legal;
    logic                  xfer;
    logic [INST_WIDTH-1:0] sel_inst;

    rr_arb2 u_rr_arb2 (
        .valid     ({req1_valid, req0_valid}),
        .pointer   (pointer),
        .lock_hold (lock_hold),
        .held_idx  (held_idx),
        .grant     (grant)
    );

    assign arb_open   = (state == ST_READY);
    assign req0_ready = arb_open & grant[0];
    assign req1_ready = arb_open & grant[1];
    assign xfer       = req0_ready | req1_ready;

    assign sel_idx   = grant[1];
    assign sel_inst  = sel_idx ? req1_inst : req0_inst;
    assign sel_lock  = sel_idx ? req1_lock : req0_lock;
    assign sel_legal = (sel_inst[OPCODE_HI:OPCODE_LO] <= OPCODE_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_RESET;
            pointer      <= 1'b0;
            lock_hold    <= 1'b0;
            held_idx     <= 1'b0;
            bank_inst    <= '0;
            bank_inst_en <= 1'b0;
            last_grant   <= 1'b0;
            issue_count  <= '0;
            error        <= 1'b0;
        end else begin
            bank_inst_en <= 1'b0;
            case (state)
                ST_RESET: begin
                    state <= ST_READY;
                end
                ST_READY: begin
                    if (xfer && sel_legal) begin
                        bank_inst    <= sel_inst;
                        bank_inst_en <= 1'b1;
                        issue_count  <= issue_count + 1'b1;
                        last_grant   <= sel_idx;
                        lock_hold    <= sel_lock;
                        held_idx     <= sel_idx;
                        if (!sel_lock) begin
                            pointer <= ~sel_idx;
                        end
                    end else if (xfer) begin
                        // accepted but swallowed: the bank must never decode it
                        bank_inst <= '0;
                        error     <= 1'b1;
                        state     <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    bank_inst <= '0;
                    error     <= 1'b1;
                end
                default: begin
                    bank_inst <= '0;
                    error     <= 1'b1;
                    state     <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_p8_arbiter.sv
// Randomized self-checking bench for regbank_p8_arbiter against a behavioural model.
module tb_regbank_p8_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] req0_inst = '0, req1_inst = '0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_lock = 1'b0, req1_lock = 1'b0;
    logic        req0_ready, req1_ready;
    logic [11:0] bank_inst;
    logic        bank_inst_en;
    logic        last_grant;
    logic [7:0]  issue_count;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int en_pulses;

    // model: phase 0 = first clock after release, 1 = arbitrating, 2 = error
    int m_phase, m_ptr, m_hold, m_hold_idx, m_inst, m_en, m_last, m_count, m_err;

    regbank_p8_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req0_inst    (req0_inst),
        .req0_valid   (req0_valid),
        .req0_lock    (req0_lock),
        .req0_ready   (req0_ready),
        .req1_inst    (req1_inst),
        .req1_valid   (req1_valid),
        .req1_lock    (req1_lock),
        .req1_ready   (req1_ready),
        .bank_inst    (bank_inst),
        .bank_inst_en (bank_inst_en),
        .last_grant   (last_grant),
        .issue_count  (issue_count),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_hold = 0; m_hold_idx = 0;
        m_inst = 0; m_en = 0; m_last = 0; m_count = 0; m_err = 0;
    endtask

    // whom the rules say gets the port this cycle, -1 for nobody
    function automatic int model_grant(input bit v0, input bit v1);
        bit v[2];
        v[0] = v0;
        v[1] = v1;
        if (m_phase != 1) return -1;
        if (m_hold != 0) return v[m_hold_idx] ? m_hold_idx : -1;
        for (int k = 0; k < 2; k++) begin
            if (v[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        check("bank_inst", 32'(bank_inst), 32'(m_inst));
        check("bank_inst_en", 32'(bank_inst_en), 32'(m_en));
        check("last_grant", 32'(last_grant), 32'(m_last));
        check("issue_count", 32'(issue_count), 32'(m_count));
        check("error", 32'(error), 32'(m_err));
    endtask

    // one clock: drive, check readies, clock, advance model, check registered outputs
    task automatic step(input bit v0, input logic [11:0] i0, input bit l0,
                        input bit v1, input logic [11:0] i1, input bit l1);
        int g, inst, lk;
        req0_valid = v0; req0_inst = i0; req0_lock = l0;
        req1_valid = v1; req1_inst = i1; req1_lock = l1;
        #1;
        g = model_grant(v0, v1);
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        @(posedge clock);
        #1;
        m_en = 0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && g >= 0) begin
            inst = (g == 1) ? int'(i1) : int'(i0);
            lk   = (g == 1) ? int'(l1) : int'(l0);
            if ((inst >> 8) <= 8) begin
                m_inst = inst; m_en = 1; m_count = (m_count + 1) % 256; m_last = g;
                m_hold = lk; m_hold_idx = g;
                if (lk == 0) m_ptr = 1 - g;
            end else begin
                m_err = 1; m_phase = 2; m_inst = 0;
            end
        end
        if (bank_inst_en) en_pulses++;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 12'h000, 0, 0, 12'h000, 0);
    endtask

    function automatic logic [11:0] legal_inst();
        logic [3:0] op;
        op = 4'($urandom_range(0, 8));
        return {op, 8'($urandom_range(0, 255))};
    endfunction

    task automatic random_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'($urandom_range(0, 1)), legal_inst(), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), legal_inst(), ($urandom_range(0, 3) == 0));
        end
    endtask

    // assert reset between edges with traffic pending; outputs must clear before any edge
    task automatic async_reset();
        @(posedge clock);
        #3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_bank_inst_en", 32'(bank_inst_en), 32'h0);
        check("rst_bank_inst", 32'(bank_inst), 32'h0);
        check("rst_issue_count", 32'(issue_count), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_last_grant", 32'(last_grant), 32'h0);
        check("rst_readies", 32'({req1_ready, req0_ready}), 32'h0);
        repeat (2) @(posedge clock);
        #4;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check("por_bank_inst_en", 32'(bank_inst_en), 32'h0);
        check("por_issue_count", 32'(issue_count), 32'h0);
        repeat (2) @(posedge clock);
        #4;
        reset = 1'b1;

        // first valid lands in the RESET cycle: held off one clock, then forwarded
        step(1, 12'h1A5, 0, 0, 12'h000, 0);
        step(1, 12'h1A5, 0, 0, 12'h000, 0);
        check("first_bank_inst", 32'(bank_inst), 32'h1A5);
        check("first_en", 32'(bank_inst_en), 32'h1);
        check("first_count", 32'(issue_count), 32'h1);

        // both valid, no lock: strict alternation
        for (int k = 0; k < 8; k++) step(1, 12'h211, 0, 1, 12'h322, 0);
        check("alt_last_grant", 32'(last_grant), 32'h0);
        check("alt_bank_inst", 32'(bank_inst), 32'h211);

        // req1 locked burst with a two-cycle gap; req0 must stay stalled throughout
        step(1, 12'h211, 0, 1, 12'h301, 1);
        step(1, 12'h211, 0, 0, 12'h000, 0);
        check("gap_req0_ready", 32'(req0_ready), 32'h0);
        step(1, 12'h211, 0, 0, 12'h000, 0);
        step(1, 12'h211, 0, 1, 12'h402, 1);
        step(1, 12'h211, 0, 1, 12'h503, 0);
        check("burst_end_inst", 32'(bank_inst), 32'h503);
        step(1, 12'h211, 0, 1, 12'h604, 0);
        check("after_burst_grant", 32'(last_grant), 32'h0);

        random_steps(300);

        // 256 NOPs from a fresh reset wrap the counter back to zero
        async_reset();
        idle();
        en_pulses = 0;
        for (int k = 0; k < 256; k++) step(1, 12'h000, 0, 0, 12'h000, 0);
        check("wrap_count", 32'(issue_count), 32'h0);
        check("wrap_pulses", 32'(en_pulses), 32'd256);

        random_steps(200);

        // reset mid-burst, then an illegal opcode
        async_reset();
        idle();
        step(1, 12'h123, 1, 1, 12'h456, 0);
        step(1, 12'h9FF, 0, 1, 12'h456, 0);
        check("illegal_en", 32'(bank_inst_en), 32'h0);
        check("illegal_error", 32'(error), 32'h1);
        check("illegal_count", 32'(issue_count), 32'h1);
        for (int k = 0; k < 10; k++) step(1, 12'h111, 0, 1, 12'h122, 0);

        // reset out of ERROR and resume normal traffic
        async_reset();
        idle();
        step(0, 12'h000, 0, 1, 12'h234, 0);
        check("resume_inst", 32'(bank_inst), 32'h234);
        check("resume_error", 32'(error), 32'h0);
        random_steps(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
